rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two requesters: pipeline writeback (port 0) and the long-latency load/multiply return path (port 1). Port 0 has fixed priority, and an age counter guarantees port 1 a grant after a bounded wait. The granted write is registered and driven onto the register file's write-enable, address and data lines one cycle after acceptance. Writes to the zero register are accepted but never reach the array.

---
 rtl/rf_write_arbiter.sv | 105 ++++++++++
 tb/tb_rf_write_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Single-write-port arbiter for the register file: writeback (port 0) has priority and an age counter bounds how long the load/mul return port (port 1) waits.
// Optional feature: define RF_WRITE_BYPASS_EN to add read-address compare ports and a bypass data output.
module rf_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
`ifdef RF_WRITE_BYPASS_EN
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DATA_W-1:0] byp_data,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        wait_cnt
);

    localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);

    logic              force1;
    logic              xfer0;
    logic              xfer1;
    logic [3:0]        wait_q;
    logic [3:0]        wait_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] wr_data_d;

    // Port 1 overrides port 0 only once it has aged out while still requesting.
    assign force1     = (wait_q == MAX_WAIT_C);
    assign req0_ready = ~stall & ~(force1 & req1_valid);
    assign req1_ready = ~stall & (~req0_valid | force1);
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

    always_comb begin
        wait_d    = 4'd0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (xfer0) begin
            wr_en_d   = (req0_addr != ZERO_ADDR);
            wr_addr_d = req0_addr;
            wr_data_d = req0_data;
        end else if (xfer1) begin
            wr_en_d   = (req1_addr != ZERO_ADDR);
            wr_addr_d = req1_addr;
            wr_data_d = req1_data;
        end

        // Age keeps climbing through stalls so a stalled port 1 wins first on release.
        if (xfer1) begin
            wait_d = 4'd0;
        end else if (req1_valid) begin
            wait_d = force1 ? wait_q : wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wait_q    <= wait_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wait_cnt = wait_q;

`ifdef RF_WRITE_BYPASS_EN
    // wr_en is never set for the zero register, so it can never produce a hit.
    assign byp_hit_a = wr_en_q & (wr_addr_q == rd_addr_a);
    assign byp_hit_b = wr_en_q & (wr_addr_q == rd_addr_b);
    assign byp_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a cycle model pushes expected write-port values, each test pops and compares after the edge.
module tb_rf_write_arbiter;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int MAXW = 4;
    localparam int ZR   = 31;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wait_cnt;
`ifdef RF_WRITE_BYPASS_EN
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          byp_hit_a;
    logic          byp_hit_b;
    logic [DW-1:0] byp_data;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    int            m_wait = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    exp_t          exp_q[$];

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MAXW), .ZERO_REG(ZR)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef RF_WRITE_BYPASS_EN
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b), .byp_data(byp_data),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wait_cnt(wait_cnt)
    );

    function automatic void model_ready(output logic r0, output logic r1);
        logic f1;
        f1 = (m_wait == MAXW);
        r0 = !stall && !(f1 && req1_valid);
        r1 = !stall && (!req0_valid || f1);
    endfunction

    // Advance the model by one edge, push the expected write-port values, then step the clock.
    task automatic cycle();
        logic r0, r1, x0, x1;
        exp_t e;
        model_ready(r0, r1);
        x0 = req0_valid && r0;
        x1 = req1_valid && r1;
        e.en = 1'b0;
        if (reset) begin
            m_addr = '0;
            m_data = '0;
            m_wait = 0;
        end else begin
            if (x0) begin
                m_addr = req0_addr; m_data = req0_data; e.en = (int'(req0_addr) != ZR);
            end else if (x1) begin
                m_addr = req1_addr; m_data = req1_data; e.en = (int'(req1_addr) != ZR);
            end
            if (x1)              m_wait = 0;
            else if (req1_valid) m_wait = (m_wait == MAXW) ? MAXW : m_wait + 1;
            else                 m_wait = 0;
        end
        e.addr = m_addr;
        e.data = m_data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic r0, r1;
        reset = 1'b1; stall = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 64'h44;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== 2'b10) begin
                    n_fail++; $display("FAIL reset_ready got %b%b exp 10", req0_ready, req1_ready);
                end
            end
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (wr_en !== 1'b0 || wait_cnt !== 4'd0 || wr_addr !== '0 || wr_data !== '0 || e.en !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out got en=%b addr=%0d data=%h wait=%0d exp 0/0/0/0", wr_en, wr_addr, wr_data, wait_cnt);
            end
        end
        reset = 1'b0;
        #1;
        model_ready(r0, r1);
        n_checks++;
        if ({req0_ready, req1_ready} !== {r0, r1}) begin
            n_fail++; $display("FAIL release_ready got %b%b exp %b%b", req0_ready, req1_ready, r0, r1);
        end
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'h33 || {e.en, e.addr} !== {1'b1, 5'd3}) begin
            n_fail++; $display("FAIL release_win got en=%b addr=%0d data=%h exp en=1 addr=3 data=33", wr_en, wr_addr, wr_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if ({wr_en, wr_addr, wr_data} !== {e.en, e.addr, e.data} || wait_cnt !== 4'(m_wait)) begin
            n_fail++; $display("FAIL reset_idle got en=%b addr=%0d wait=%0d exp en=%b addr=%0d wait=%0d", wr_en, wr_addr, wait_cnt, e.en, e.addr, m_wait);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA5;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hA5 || {e.en, e.addr, e.data} !== {1'b1, 5'd5, 64'hA5}) begin
            n_fail++; $display("FAIL single_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=a5", wr_en, wr_addr, wr_data);
        end
        req0_valid = 1'b0;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 64'hA5) begin
            n_fail++; $display("FAIL single_after got en=%b addr=%0d data=%h exp en=0 addr=5 data=a5", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        logic [AW-1:0] win;
        req0_valid = 1'b1; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_addr = 5'd2;
        for (int k = 0; k < 15; k++) begin
            req0_data = {32'h0, $urandom};
            req1_data = {32'h1, $urandom};
            n_checks++;
            if (wait_cnt !== 4'(k % 5)) begin
                n_fail++; $display("FAIL starve_wait k=%0d got %0d exp %0d", k, wait_cnt, k % 5);
            end
            cycle();
            e = exp_q.pop_front();
            win = (k % 5 == 4) ? 5'd2 : 5'd1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== win || {wr_en, wr_addr, wr_data} !== {e.en, e.addr, e.data}) begin
                n_fail++; $display("FAIL starve_win k=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h", k, wr_en, wr_addr, wr_data, win, e.data);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_zero_reg();
        exp_t e;
        req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 64'hDEAD;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_ready got %b exp 1", req1_ready);
        end
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd31 || wr_data !== 64'hDEAD || e.en !== 1'b0) begin
            n_fail++; $display("FAIL zero_write got en=%b addr=%0d data=%h exp en=0 addr=31 data=dead", wr_en, wr_addr, wr_data);
        end
        req1_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_stall();
        exp_t e;
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 64'h99;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 64'hAA;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wait_cnt !== 4'd1) begin
            n_fail++; $display("FAIL stall_pre got en=%b addr=%0d wait=%0d exp en=1 addr=9 wait=1", wr_en, wr_addr, wait_cnt);
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_fail++; $display("FAIL stall_ready i=%0d got %b%b exp 00", i, req0_ready, req1_ready);
            end
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (wr_en !== 1'b0 || {wr_addr, wr_data} !== {e.addr, e.data} || wait_cnt !== 4'(m_wait)) begin
                n_fail++; $display("FAIL stall_out i=%0d got en=%b addr=%0d wait=%0d exp en=0 addr=%0d wait=%0d", i, wr_en, wr_addr, wait_cnt, e.addr, m_wait);
            end
        end
        n_checks++;
        if (wait_cnt !== 4'd4) begin
            n_fail++; $display("FAIL stall_sat got %0d exp 4", wait_cnt);
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL stall_release_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_data !== 64'hAA || wait_cnt !== 4'd0) begin
            n_fail++; $display("FAIL stall_release_win got en=%b addr=%0d data=%h wait=%0d exp en=1 addr=10 data=aa wait=0", wr_en, wr_addr, wr_data, wait_cnt);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        exp_t e;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 64'hC0;
        cycle();
        void'(exp_q.pop_front());
        reset = 1'b1; req0_addr = 5'd13; req0_data = 64'hD0;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || e.en !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got en=%b addr=%0d data=%h exp en=0 addr=0 data=0", wr_en, wr_addr, wr_data);
        end
        reset = 1'b0; req0_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic r0, r1;
        int   bad;
        bad = 0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_addr = 5'(i + 16); req0_data = 64'(i * 3 + 1);
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(i + 16) || wr_data !== 64'(i * 3 + 1)) begin
                n_fail++; $display("FAIL b2b_stream i=%0d got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%0h", i, wr_en, wr_addr, wr_data, i + 16, i * 3 + 1);
            end
        end
        for (int i = 0; i < 300; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 7) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            req0_data  = {$urandom, $urandom};
            req1_data  = {$urandom, $urandom};
            #1;
            model_ready(r0, r1);
            n_checks++;
            if ({req0_ready, req1_ready} !== {r0, r1}) begin
                n_fail++; $display("FAIL rand_ready i=%0d got %b%b exp %b%b", i, req0_ready, req1_ready, r0, r1);
            end
            cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({wr_en, wr_addr, wr_data} !== {e.en, e.addr, e.data} || wait_cnt !== 4'(m_wait)) begin
                n_fail++;
                $display("FAIL rand_out i=%0d got en=%b addr=%0d data=%h wait=%0d exp en=%b addr=%0d data=%h wait=%0d",
                         i, wr_en, wr_addr, wr_data, wait_cnt, e.en, e.addr, e.data, m_wait);
            end
        end
        reset = 1'b0; stall = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
        bad = exp_q.size();
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got %0d entries left exp 0", bad);
        end
    endtask

`ifdef RF_WRITE_BYPASS_EN
    task automatic test_bypass();
        exp_t e;
        rd_addr_a = 5'd7; rd_addr_b = 5'd8;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h1234;
        cycle();
        e = exp_q.pop_front();
        n_checks++;
        if (byp_hit_a !== 1'b1 || byp_hit_b !== 1'b0 || byp_data !== 64'h1234 || e.en !== 1'b1) begin
            n_fail++; $display("FAIL bypass got hit_a=%b hit_b=%b data=%h exp 1 0 1234", byp_hit_a, byp_hit_b, byp_data);
        end
        req0_addr = 5'd31; rd_addr_a = 5'd31;
        cycle();
        void'(exp_q.pop_front());
        n_checks++;
        if (byp_hit_a !== 1'b0) begin
            n_fail++; $display("FAIL bypass_zero got hit_a=%b exp 0", byp_hit_a);
        end
        req0_valid = 1'b0;
        cycle();
        void'(exp_q.pop_front());
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_starvation();
        test_zero_reg();
        test_stall();
        test_reset_mid();
`ifdef RF_WRITE_BYPASS_EN
        test_bypass();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
